// File: rtl/sll_iter_32bit_pkg.sv
// Shared types and constants for the iterative logical left shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int STAGES  = 5;
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/sll_iter_32bit_if.sv
// Operand/result handshake bundle for sll_iter_32bit.
interface sll_iter_32bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in;
  logic [31:0] shift_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  modport master (
    output in_valid, in, shift_sel, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, shift_sel, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/sll_iter_32bit_mux.sv
// Single 2:1 word mux reused by every shift stage.
module mux2to1_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/sll_iter_32bit.sv
// Multi-cycle logical left shifter: one log stage (1,2,4,8,16) per clock.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | applying stage 0..4, one per clock
// DONE  | result presented, out_valid=1 until out_ready
module sll_iter_32bit
  import shifter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sll_iter_32bit_if.slave  bus
);

  state_e             state;
  logic [31:0]        acc;
  logic [SHAMT_W-1:0] shamt_q;
  logic [2:0]         stage;
  logic [31:0]        shifted;
  logic [31:0]        acc_next;
  logic               unused_shift_hi;

  // Upper shift-amount bits carry no meaning for a 32-bit shift.
  assign unused_shift_hi = ^bus.shift_sel[31:SHAMT_W];

  always_comb begin
    shifted = acc;
    case (stage)
      3'd0:    shifted = {acc[30:0], 1'b0};
      3'd1:    shifted = {acc[29:0], 2'b0};
      3'd2:    shifted = {acc[27:0], 4'b0};
      3'd3:    shifted = {acc[23:0], 8'b0};
      3'd4:    shifted = {acc[15:0], 16'b0};
      default: shifted = acc;
    endcase
  end

  mux2to1_32bit u_stage_mux (
    .a   (acc),
    .b   (shifted),
    .sel (shamt_q[stage]),
    .y   (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      shamt_q <= '0;
      stage   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc     <= bus.in;
            shamt_q <= bus.shift_sel[SHAMT_W-1:0];
            stage   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          if (stage == 3'(STAGES - 1)) begin
            stage <= '0;
            state <= DONE;
          end else begin
            stage <= stage + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = acc;

endmodule

// File: tb/tb_sll_iter_32bit.sv
// Directed and random checks for sll_iter_32bit.
module tb_sll_iter_32bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec_count = 0;
  int   err_count = 0;

  sll_iter_32bit_if bus ();

  sll_iter_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Present an operand at the current negedge and wait for out_valid.
  // lat = number of clock edges after acceptance; -1 if never valid.
  task automatic run_op(input logic [31:0] din, input logic [31:0] sel,
                        output logic [31:0] res, output int lat);
    bus.in_valid  = 1'b1;
    bus.in        = din;
    bus.shift_sel = sel;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.out;
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vec_count++;
    if (bus.in_ready !== 1'b1) begin
      err_count++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    vec_count++;
    if (bus.out_valid !== 1'b0) begin
      err_count++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    vec_count++;
    if (bus.out !== 32'h0) begin
      err_count++; $display("FAIL reset_out got=%h exp=00000000", bus.out);
    end
  endtask

  task automatic test_shift31();
    logic [31:0] res;
    int lat;
    bus.out_ready = 1'b1;
    run_op(32'h0000_0001, 32'd31, res, lat);
    vec_count++;
    if (lat !== 5) begin
      err_count++; $display("FAIL shift31_latency got=%0d exp=5", lat);
    end
    vec_count++;
    if (res !== 32'h8000_0000) begin
      err_count++; $display("FAIL shift31_out got=%h exp=80000000", res);
    end
    @(negedge clk);
    vec_count++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL shift31_return in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_upper_ignored();
    logic [31:0] res;
    int lat;
    run_op(32'hF000_000F, 32'h0000_0024, res, lat);
    vec_count++;
    if (res !== 32'h0000_00F0 || lat !== 5) begin
      err_count++; $display("FAIL upper_ignored got=%h lat=%0d exp=000000f0 lat=5", res, lat);
    end
    release_op();
  endtask

  task automatic test_zero();
    logic [31:0] res;
    int lat;
    run_op(32'hDEAD_BEEF, 32'h0, res, lat);
    vec_count++;
    if (res !== 32'hDEAD_BEEF || lat !== 5) begin
      err_count++; $display("FAIL zero_shift got=%h lat=%0d exp=deadbeef lat=5", res, lat);
    end
    release_op();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in        = 32'h0000_00FF;
    bus.shift_sel = 32'd3;
    @(negedge clk);
    bus.in        = 32'hAAAA_AAAA;
    bus.shift_sel = 32'd1;
    repeat (5) @(negedge clk);
    vec_count++;
    if (bus.out_valid !== 1'b1 || bus.out !== 32'h0000_07F8) begin
      err_count++; $display("FAIL bp_first got=%h valid=%b exp=000007f8 valid=1", bus.out, bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_count++;
      if (bus.out_valid !== 1'b1 || bus.out !== 32'h0000_07F8) begin
        err_count++; $display("FAIL bp_hold%0d got=%h valid=%b exp=000007f8 valid=1", i, bus.out, bus.out_valid);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    vec_count++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== 32'h0000_07F8) begin
      err_count++;
      $display("FAIL bp_release in_ready=%b out_valid=%b out=%h exp 1/0/000007f8", bus.in_ready, bus.out_valid, bus.out);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    int seen_valid;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in        = 32'hFFFF_FFFF;
    bus.shift_sel = 32'd31;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_count++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== 32'h0) begin
      err_count++;
      $display("FAIL midreset_state in_ready=%b out_valid=%b out=%h exp 1/0/00000000", bus.in_ready, bus.out_valid, bus.out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
    vec_count++;
    if (seen_valid != 0) begin
      err_count++; $display("FAIL midreset_no_valid got=%0d exp=0", seen_valid);
    end
    bus.out_ready = 1'b0;
    run_op(32'h1234_5678, 32'd8, res, lat);
    vec_count++;
    if (res !== 32'h3456_7800 || lat !== 5) begin
      err_count++; $display("FAIL midreset_next got=%h lat=%0d exp=34567800 lat=5", res, lat);
    end
    release_op();
  endtask

  task automatic test_random();
    logic [31:0] din, sel, res, exp_val;
    int lat;
    int waits;
    for (int i = 0; i < 1000; i++) begin
      din = $urandom;
      sel = {$urandom_range(0, 32'h07FF_FFFF), 5'(i)};
      case (sel[4:0])
        5'd0:    exp_val = din;
        default: exp_val = din << sel[4:0];
      endcase
      bus.out_ready = 1'b0;
      run_op(din, sel, res, lat);
      vec_count++;
      if (res !== exp_val || lat !== 5) begin
        err_count++;
        $display("FAIL rand%0d in=%h sh=%0d got=%h lat=%0d exp=%h lat=5", i, din, sel[4:0], res, lat, exp_val);
      end
      waits = 0;
      do begin
        bus.out_ready = (waits >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        waits++;
        if (bus.out_valid && bus.out !== exp_val) begin
          vec_count++;
          err_count++;
          $display("FAIL rand_hold%0d got=%h exp=%h", i, bus.out, exp_val);
        end
      end while (bus.out_valid);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.shift_sel = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_shift31();
    test_upper_ignored();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
